// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared op codes, FSM states and the GF(2^m) xtime helper
package gf2m_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_INV = 1'b1;
  typedef enum logic [2:0] {IDLE, MUL_RUN, INV_SQ, INV_MA, DONE} state_t;
  function automatic logic [15:0] gf_xtime(input logic [15:0] v, input logic [16:0] poly, input int m);
    logic [16:0] s;
    s = {v, 1'b0} ^ (v[m-1] ? poly : 17'h0);
    return s[15:0] & 16'((17'h1 << m) - 17'h1);
  endfunction
endpackage

// File: rtl/gf2m_bitserial_mul.sv
// gf2m_bitserial_mul: M-cycle MSB-first GF(2^M) multiply pass; start/x/y in, busy/done(1-cycle pulse)/p out
module gf2m_bitserial_mul
  import gf2m_pkg::*;
#(
  parameter int          M    = 8,
  parameter int unsigned POLY = 'h11B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] p
);
  localparam int CW = $clog2(M);
  logic [M-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d, xt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  assign xt = M'(gf_xtime(16'(acc_q), 17'(POLY), M));
  always_comb begin
    acc_d = acc_q;
    x_d = x_q;
    y_d = y_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      acc_d = y[M-1] ? x : '0;
      x_d = x;
      y_d = y << 1;
      cnt_d = CW'(M - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = xt ^ (y_q[M-1] ? x_q : '0);
      y_d = y_q << 1;
      cnt_d = cnt_q - 1'b1;
      busy_d = cnt_q != CW'(1);
      done_d = cnt_q == CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      x_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      x_q <= x_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign p = acc_q;
endmodule

// File: rtl/gf2m_mul_inv_seq.sv
// gf2m_mul_inv_seq: GF(2^M) multiply/inverse unit; in_valid/in_ready/in_op/in_a/in_b/in_tag in, out_valid/out_ready/out_data/out_tag out
module gf2m_mul_inv_seq
  import gf2m_pkg::*;
#(
  parameter int          M     = 8,
  parameter int unsigned POLY  = 'h11B,
  parameter int          TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [M-1:0]     in_a,
  input  logic [M-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(M);
  if (M < 3 || M > 16 || POLY[M] != 1'b1) begin : g_bad_param
    $error("gf2m_mul_inv_seq: M must be 3..16 and POLY[M] must be 1");
  end
  state_t state_q, state_d;
  logic [M-1:0] a_q, a_d, out_data_q, out_data_d, mul_x, mul_y, mul_p;
  logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mul_start, mul_busy, mul_done, accept, fin;
  assign in_ready = state_q == IDLE && !mul_busy;
  assign accept = in_valid && in_ready;
  assign fin = mul_done && (state_q == MUL_RUN || (state_q == INV_SQ && cnt_q == '0));
  assign mul_x = state_q == IDLE ? in_a : mul_p;
  assign mul_y = state_q == IDLE ? (in_op == OP_INV ? in_a : in_b) : state_q == INV_SQ ? a_q : mul_p;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    out_data_d = out_data_q;
    out_tag_d = out_tag_q;
    mul_start = 1'b0;
    if (accept) begin
      mul_start = 1'b1;
      a_d = in_a;
      tag_d = in_tag;
      cnt_d = CW'(M - 2);
      state_d = in_op == OP_INV ? INV_SQ : MUL_RUN;
    end else if (fin) begin
      out_data_d = mul_p;
      out_tag_d = tag_q;
      state_d = DONE;
    end else if (mul_done && state_q == INV_SQ) begin
      mul_start = 1'b1;
      state_d = INV_MA;
    end else if (mul_done && state_q == INV_MA) begin
      mul_start = 1'b1;
      cnt_d = cnt_q - 1'b1;
      state_d = INV_SQ;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      out_data_q <= '0;
      out_tag_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      out_tag_q <= out_tag_d;
    end
  end
  gf2m_bitserial_mul #(.M(M), .POLY(POLY)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(mul_start),
    .x(mul_x),
    .y(mul_y),
    .busy(mul_busy),
    .done(mul_done),
    .p(mul_p)
  );
  assign out_valid = state_q == DONE;
  assign out_data = out_data_q;
  assign out_tag = out_tag_q;
endmodule

// File: tb/tb_gf2m_mul_inv_seq.sv
// tb_gf2m_mul_inv_seq: directed, exhaustive and random checks of gf2m_mul_inv_seq at M=8 (AES) and M=4 (GF(16))
module tb_gf2m_mul_inv_seq;
  import gf2m_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv8, ir8, op8, ov8, or8;
  logic [7:0] a8, b8, od8;
  logic [3:0] t8, ot8;
  logic iv4, ir4, op4, ov4, or4;
  logic [3:0] a4, b4, od4, t4, ot4;
  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp4 [0:14];
  int log4 [0:15];
  gf2m_mul_inv_seq #(.M(8), .POLY('h11B), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_op(op8), .in_a(a8), .in_b(b8),
    .in_tag(t8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_tag(ot8)
  );
  gf2m_mul_inv_seq #(.M(4), .POLY('h13), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_op(op4), .in_a(a4), .in_b(b4),
    .in_tag(t4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_tag(ot4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] ref_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] x;
    logic [7:0] r;
    x = {8'h0, a};
    r = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x[7:0];
      x = gf_xtime(x, 17'h11B, 8);
    end
    return r;
  endfunction
  function automatic logic [7:0] ref_inv8(input logic [7:0] a);
    for (int y = 1; y < 256; y++) if (ref_mul8(a, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction
  function automatic logic [3:0] ref_mul4(input logic [3:0] a, input logic [3:0] b);
    return (a == 4'h0 || b == 4'h0) ? 4'h0 : exp4[(log4[a] + log4[b]) % 15];
  endfunction
  function automatic logic [3:0] ref_inv4(input logic [3:0] a);
    return a == 4'h0 ? 4'h0 : exp4[(15 - log4[a]) % 15];
  endfunction
  function automatic logic g_valid(input bit w4);
    return w4 ? ov4 : ov8;
  endfunction
  function automatic logic g_ready(input bit w4);
    return w4 ? ir4 : ir8;
  endfunction
  function automatic logic [7:0] g_data(input bit w4);
    return w4 ? {4'h0, od4} : od8;
  endfunction
  function automatic logic [3:0] g_tag(input bit w4);
    return w4 ? ot4 : ot8;
  endfunction
  task automatic drive(input bit w4, input logic v, input logic op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    if (w4) begin
      iv4 = v; op4 = op; a4 = a[3:0]; b4 = b[3:0]; t4 = t;
    end else begin
      iv8 = v; op8 = op; a8 = a; b8 = b; t8 = t;
    end
  endtask
  task automatic junk(input bit w4);
    drive(w4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'($urandom));
  endtask
  task automatic set_ordy(input bit w4, input logic r);
    if (w4) or4 = r;
    else or8 = r;
  endtask
  task automatic run_op(input bit w4, input logic op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] want,
                        input logic [3:0] t, input int gap, input int hold, input string name, output logic [7:0] res);
    int m;
    int lat;
    m = w4 ? 4 : 8;
    lat = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    drive(w4, 1'b1, op, a, b, t);
    @(posedge clk);
    #1;
    junk(w4);
    while (g_valid(w4) !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"}, lat, op == OP_INV ? (2 * m - 3) * m : m);
    check({name, "_data"}, g_data(w4), want);
    check({name, "_tag"}, g_tag(w4), t);
    res = g_data(w4);
    repeat (hold) begin
      junk(w4);
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      check({name, "_bp_valid"}, g_valid(w4), 1);
      check({name, "_bp_data"}, g_data(w4), want);
      check({name, "_bp_tag"}, g_tag(w4), t);
      check({name, "_bp_ready"}, g_ready(w4), 0);
    end
    junk(w4);
    set_ordy(w4, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(w4, 1'b0);
    drive(w4, 1'b0, 1'b0, 8'h0, 8'h0, 4'h0);
    check({name, "_hs_valid"}, g_valid(w4), 0);
    check({name, "_hs_ready"}, g_ready(w4), 1);
    check({name, "_hs_data"}, g_data(w4), want);
  endtask
  initial begin
    logic [15:0] e;
    logic [7:0] res;
    logic op;
    logic [7:0] a, b, w;
    e = 16'h1;
    for (int i = 0; i < 15; i++) begin
      exp4[i] = e[3:0];
      log4[e[3:0]] = i;
      e = gf_xtime(e, 17'h13, 4);
    end
    log4[0] = 0;
    drive(0, 1'b0, 1'b0, 8'h0, 8'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 8'h0, 4'h0);
    or8 = 1'b0;
    or4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready8", ir8, 1);
    check("rst_valid8", ov8, 0);
    check("rst_data8", od8, 0);
    check("rst_tag8", ot8, 0);
    check("rst_ready4", ir4, 1);
    check("rst_valid4", ov4, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(0, OP_MUL, 8'h57, 8'h83, 8'hC1, 4'd3, 0, 0, "mul8_57x83", res);
    run_op(0, OP_MUL, 8'h57, 8'h13, 8'hFE, 4'd5, 1, 0, "mul8_57x13", res);
    run_op(0, OP_INV, 8'h53, 8'h00, 8'hCA, 4'd1, 0, 0, "inv8_53", res);
    run_op(0, OP_INV, 8'h01, 8'hFF, 8'h01, 4'd2, 0, 0, "inv8_01", res);
    run_op(0, OP_INV, 8'h00, 8'h12, 8'h00, 4'd7, 0, 0, "inv8_00", res);
    run_op(1, OP_MUL, 8'h02, 8'h09, 8'h01, 4'd4, 0, 0, "mul4_2x9", res);
    run_op(1, OP_INV, 8'h02, 8'h00, 8'h09, 4'd6, 0, 0, "inv4_2", res);
    run_op(0, OP_MUL, 8'hCA, 8'h53, 8'h01, 4'd9, 0, 10, "bp8", res);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(1, OP_MUL, 8'(x), 8'(y), {4'h0, ref_mul4(4'(x), 4'(y))}, 4'(x ^ y), 0, 0, "mul4_exh", res);
    for (int x = 1; x < 16; x++) begin
      run_op(1, OP_INV, 8'(x), 8'h0, {4'h0, ref_inv4(4'(x))}, 4'(x), 0, 0, "inv4_all", res);
      check("inv4_prod", ref_mul4(res[3:0], 4'(x)), 1);
    end
    drive(0, 1'b1, OP_INV, 8'h53, 8'h00, 4'hA);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 8'h0, 8'h0, 4'h0);
    repeat (49) begin
      @(posedge clk);
      #1;
    end
    check("abort_pre_valid", ov8, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", ir8, 1);
    check("abort_valid", ov8, 0);
    check("abort_data", od8, 0);
    check("abort_tag", ot8, 0);
    check("abort_data4", od4, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_no_stale", ov8, 0);
    end
    run_op(0, OP_MUL, 8'h57, 8'h83, 8'hC1, 4'd3, 0, 0, "post_rst_mul8", res);
    for (int i = 0; i < 1000; i++) begin
      op = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      b = 8'($urandom_range(0, 15));
      w = op == OP_INV ? {4'h0, ref_inv4(a[3:0])} : {4'h0, ref_mul4(a[3:0], b[3:0])};
      run_op(1, op, a, b, w, 4'($urandom), $urandom_range(0, 1) ? 0 : $urandom_range(1, 3),
             $urandom_range(0, 1) ? 0 : $urandom_range(1, 3), "rnd4", res);
    end
    for (int i = 0; i < 100; i++) begin
      op = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      w = op == OP_INV ? ref_inv8(a) : ref_mul8(a, b);
      run_op(0, op, a, b, w, 4'($urandom), $urandom_range(0, 1) ? 0 : $urandom_range(1, 3),
             $urandom_range(0, 1) ? 0 : $urandom_range(1, 3), "rnd8", res);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
